// File: rtl/hs_sync_receiver.sv
// Clocked consumer end of a 4-phase bundled-data req/ack channel: synchronizes req, captures data into a FIFO.
// Optional protocol checker enabled by defining HS_PROTOCOL_CHECK_EN (default build: proto_err_o tied 0).
module hs_sync_receiver #(
  parameter int DataWidth  = 32,
  parameter int Depth      = 2,
  parameter int SyncStages = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [DataWidth-1:0]       data_i,
  output logic                       ack_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth-1:0]       data_o,
  output logic [$clog2(Depth+1)-1:0] fill_o,
  output logic                       proto_err_o
);

  localparam int FillW = $clog2(Depth + 1);
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic [SyncStages-1:0] r_sync;
  logic [DataWidth-1:0]  r_mem [Depth];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [FillW-1:0]      r_fill;

  logic w_req_s;
  logic w_not_full;
  logic w_push;
  logic w_pop;

  assign w_req_s    = r_sync[SyncStages-1];
  assign w_not_full = (r_fill < FillW'(Depth));
  assign w_push     = (r_state == ST_IDLE) && w_req_s && w_not_full;
  assign w_pop      = (r_fill != '0) && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], req_i};
    end
  end

  // A full FIFO keeps the FSM in IDLE with ack low, back-pressuring the sender.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!w_req_s) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign ack_o   = r_ack;
  assign valid_o = (r_fill != '0);
  assign data_o  = r_mem[r_rptr];
  assign fill_o  = r_fill;

`ifdef HS_PROTOCOL_CHECK_EN
  logic       r_req_s_q;
  logic [9:0] r_ack_cnt;
  logic       r_proto_err;

  // Flags a request withdrawn while held off, or a sender stuck in ACK for too long.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_s_q   <= 1'b0;
      r_ack_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_req_s_q <= w_req_s;
      if (r_state == ST_ACK) begin
        if (r_ack_cnt != '1) begin
          r_ack_cnt <= r_ack_cnt + 1'b1;
        end
      end else begin
        r_ack_cnt <= '0;
      end
      if (((r_state == ST_IDLE) && r_req_s_q && !w_req_s) ||
          ((r_state == ST_ACK) && (r_ack_cnt == '1))) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err_o = r_proto_err;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hs_sync_receiver.sv
// Self-checking bench for hs_sync_receiver: queue-based channel model checked every cycle plus directed literal checks.
module tb_hs_sync_receiver;

   localparam int DataWidth  = 32;
   localparam int Depth      = 2;
   localparam int SyncStages = 2;
   localparam int FillW      = $clog2(Depth + 1);

   logic                 clk_i   = 1'b0;
   logic                 rst_ni  = 1'b0;
   logic                 req_i   = 1'b0;
   logic [DataWidth-1:0] data_i  = '0;
   logic                 ready_i = 1'b0;
   logic                 ack_o;
   logic                 valid_o;
   logic [DataWidth-1:0] data_o;
   logic [FillW-1:0]     fill_o;
   logic                 proto_err_o;

   int testsRun    = 0;
   int testsFailed = 0;

   // Model state: the FIFO as a queue, req history as the synchronizer delay.
   logic [31:0] modelQ [$];
   bit          reqHist [$];
   bit          modelAck = 1'b0;
   bit          modelReqS;
   bit          modelPush;
   bit          modelPop;

   // Streaming bookkeeping.
   logic [31:0] popLog [$];
   int          maxFill  = 0;
   bit          inStream = 1'b0;

   always #5 clk_i = ~clk_i;

   hs_sync_receiver #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .SyncStages(SyncStages)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .data_i     (data_i),
      .ack_o      (ack_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .fill_o     (fill_o),
      .proto_err_o(proto_err_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] data, input logic ready);
      req_i   = req;
      data_i  = data;
      ready_i = ready;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic waitAck(input logic want, input int budget, input string name);
      int n = 0;
      while (ack_o !== want && n < budget) begin
         tick(1);
         n++;
      end
      testsRun++;
      if (ack_o !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: ack_o timed out, got %0b, expected %0b", name, ack_o, want);
      end
   endtask

   task automatic sendToken(input logic [31:0] data, input logic ready);
      applyStimulus(1'b1, data, ready);
      waitAck(1'b1, 20, "send_ack_rise");
      applyStimulus(1'b0, data, ready);
      waitAck(1'b0, 20, "send_ack_fall");
   endtask

   // Channel model: req seen SyncStages edges late, one write per handshake when not full.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         modelQ.delete();
         reqHist.delete();
         modelAck = 1'b0;
      end else begin
         modelReqS = (reqHist.size() == SyncStages) ? reqHist[0] : 1'b0;
         reqHist.push_back(req_i);
         if (reqHist.size() > SyncStages) void'(reqHist.pop_front());
         modelPop  = (modelQ.size() != 0) && ready_i;
         modelPush = !modelAck && modelReqS && (modelQ.size() < Depth);
         if (modelPop) void'(modelQ.pop_front());
         if (modelPush) begin
            modelQ.push_back(data_i);
            modelAck = 1'b1;
         end else if (modelAck && !modelReqS) begin
            modelAck = 1'b0;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(posedge clk_i) begin
      #1;
      if (rst_ni) begin
         checkOutput("ack_o", {31'd0, ack_o}, {31'd0, modelAck});
         checkOutput("valid_o", {31'd0, valid_o}, (modelQ.size() != 0) ? 32'd1 : 32'd0);
         checkOutput("fill_o", 32'(fill_o), 32'(modelQ.size()));
         if (modelQ.size() != 0) checkOutput("data_o", data_o, modelQ[0]);
`ifndef HS_PROTOCOL_CHECK_EN
         checkOutput("proto_err_o", {31'd0, proto_err_o}, 32'd0);
`endif
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni && inStream && valid_o && ready_i) popLog.push_back(data_o);
   end

   always @(negedge clk_i) begin
      if (inStream && int'(fill_o) > maxFill) maxFill = int'(fill_o);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick(3);
      checkOutput("reset_ack", {31'd0, ack_o}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("reset_fill", 32'(fill_o), 32'd0);
      checkOutput("reset_proto", {31'd0, proto_err_o}, 32'd0);
      rst_ni = 1'b1;

      $display("[TB] single token");
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
      tick(2);
      checkOutput("single_ack_edge2", {31'd0, ack_o}, 32'd0);
      tick(1);
      checkOutput("single_ack_edge3", {31'd0, ack_o}, 32'd1);
      checkOutput("single_valid", {31'd0, valid_o}, 32'd1);
      checkOutput("single_data", data_o, 32'hDEADBEEF);
      checkOutput("single_fill", 32'(fill_o), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick(2);
      checkOutput("single_ackfall_edge2", {31'd0, ack_o}, 32'd1);
      tick(1);
      checkOutput("single_ackfall_edge3", {31'd0, ack_o}, 32'd0);
      checkOutput("single_fill_kept", 32'(fill_o), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("single_drained", 32'(fill_o), 32'd0);

      $display("[TB] back-pressure");
      sendToken(32'h1, 1'b0);
      sendToken(32'h2, 1'b0);
      checkOutput("bp_fill_full", 32'(fill_o), 32'd2);
      applyStimulus(1'b1, 32'h3, 1'b0);
      tick(6);
      checkOutput("bp_third_held", {31'd0, ack_o}, 32'd0);
      checkOutput("bp_head_first", data_o, 32'h1);
      applyStimulus(1'b1, 32'h3, 1'b1);
      tick(1);
      checkOutput("bp_no_push_on_pop", {31'd0, ack_o}, 32'd0);
      checkOutput("bp_fill_after_pop", 32'(fill_o), 32'd1);
      checkOutput("bp_head_second", data_o, 32'h2);
      applyStimulus(1'b1, 32'h3, 1'b0);
      tick(1);
      checkOutput("bp_third_acked", {31'd0, ack_o}, 32'd1);
      checkOutput("bp_fill_refull", 32'(fill_o), 32'd2);
      applyStimulus(1'b0, 32'h3, 1'b0);
      waitAck(1'b0, 20, "bp_ack_fall");
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("bp_order_third", data_o, 32'h3);
      tick(1);
      checkOutput("bp_drained", 32'(fill_o), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] streaming");
      popLog.delete();
      maxFill  = 0;
      inStream = 1'b1;
      for (int i = 0; i < 8; i++) sendToken(32'h10 + 32'(i), 1'b1);
      tick(2);
      inStream = 1'b0;
      checkOutput("stream_count", 32'(popLog.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < popLog.size()) checkOutput("stream_order", popLog[i], 32'h10 + 32'(i));
      end
      checkOutput("stream_max_fill", 32'(maxFill), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] held request");
      applyStimulus(1'b1, 32'h55, 1'b0);
      tick(50);
      checkOutput("held_single_write", 32'(fill_o), 32'd1);
      checkOutput("held_ack_high", {31'd0, ack_o}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick(2);
      checkOutput("held_ack_edge2", {31'd0, ack_o}, 32'd1);
      tick(1);
      checkOutput("held_ack_edge3", {31'd0, ack_o}, 32'd0);
      checkOutput("held_fill_after", 32'(fill_o), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] reset mid-transfer");
      applyStimulus(1'b1, 32'h77, 1'b0);
      waitAck(1'b1, 20, "rst_pre_ack");
      checkOutput("rst_pre_fill", 32'(fill_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("rst_async_ack", {31'd0, ack_o}, 32'd0);
      checkOutput("rst_async_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("rst_async_fill", 32'(fill_o), 32'd0);
      tick(1);
      rst_ni = 1'b1;
      sendToken(32'hA5, 1'b0);
      checkOutput("rst_next_data", data_o, 32'hA5);
      checkOutput("rst_next_fill", 32'(fill_o), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] withdrawn request");
      sendToken(32'hB1, 1'b0);
      sendToken(32'hB2, 1'b0);
      applyStimulus(1'b1, 32'hB3, 1'b0);
      tick(5);
      applyStimulus(1'b0, 32'hB3, 1'b0);
      tick(5);
      checkOutput("withdraw_no_ack", {31'd0, ack_o}, 32'd0);
      checkOutput("withdraw_fill", 32'(fill_o), 32'd2);
`ifdef HS_PROTOCOL_CHECK_EN
      checkOutput("withdraw_proto_err", {31'd0, proto_err_o}, 32'd1);
      tick(3);
      checkOutput("withdraw_proto_sticky", {31'd0, proto_err_o}, 32'd1);
`else
      checkOutput("withdraw_proto_err", {31'd0, proto_err_o}, 32'd0);
`endif
      rst_ni = 1'b0;
      tick(1);
      checkOutput("withdraw_proto_reset", {31'd0, proto_err_o}, 32'd0);
      checkOutput("withdraw_fill_reset", 32'(fill_o), 32'd0);
      rst_ni = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
